// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the 2:1 AXI4-Lite write-channel arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered one-hot grant.
// The priority pointer moves to the master that was not just served.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic [1:0] winner;

  // Pick a winner: a lone requester wins, a tie goes to the pointer's master.
  always_comb begin
    winner = GRANT_NONE;
    case (req)
      2'b01:   winner = GRANT_M0;
      2'b10:   winner = GRANT_M1;
      2'b11:   winner = ptr ? GRANT_M1 : GRANT_M0;
      default: winner = GRANT_NONE;
    endcase
  end

  // Grant and pointer registers: load in IDLE, release and rotate on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= GRANT_NONE;
      ptr   <= 1'b0;
    end else if (advance) begin
      ptr   <= grant[0];
      grant <= GRANT_NONE;
    end else if (load && (req != 2'b00)) begin
      grant <= winner;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// 2:1 AXI4-Lite write-channel arbiter: one outstanding transaction, registered
// B response to the owner, and a timeout that answers SLVERR on a hung slave.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned AXI_AWIDTH     = 32,
  parameter int unsigned AXI_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic [AXI_AWIDTH-1:0]   M0_AWADDR,
  input  logic                    M0_AWVALID,
  output logic                    M0_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   M0_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] M0_WSTRB,
  input  logic                    M0_WVALID,
  output logic                    M0_WREADY,
  output logic [1:0]              M0_BRESP,
  output logic                    M0_BVALID,
  input  logic                    M0_BREADY,
  input  logic [AXI_AWIDTH-1:0]   M1_AWADDR,
  input  logic                    M1_AWVALID,
  output logic                    M1_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   M1_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] M1_WSTRB,
  input  logic                    M1_WVALID,
  output logic                    M1_WREADY,
  output logic [1:0]              M1_BRESP,
  output logic                    M1_BVALID,
  input  logic                    M1_BREADY,
  output logic [AXI_AWIDTH-1:0]   S_AWADDR,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [AXI_DWIDTH-1:0]   S_WDATA,
  output logic [AXI_DWIDTH/8-1:0] S_WSTRB,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  input  logic [1:0]              S_BRESP,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  output logic [1:0]              GRANT
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t    state_q, state_d;
  logic [1:0]    grant;
  logic          unused_ptr;
  logic [1:0]    req;
  logic          aw_done_q, w_done_q, b_done_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic [CW-1:0] tmo_cnt_q;
  logic          in_xfer, in_resp, sel_m1;
  logic          sel_awvalid, sel_wvalid, sel_bready;
  logic          aw_hs, w_hs, b_hs, all_done, tmo_fire, advance;

  assign req     = {M1_AWVALID | M1_WVALID, M0_AWVALID | M0_WVALID};
  assign in_xfer = (state_q == XFER);
  assign in_resp = (state_q == RESP);
  assign sel_m1  = grant[1];
  assign GRANT   = grant;

  // The pointer is kept inside the arbiter; the top only needs the grant.
  rr_arb2 u_rr_arb2 (
    .clk     (AXI_ACLK),
    .rst_n   (AXI_ARESETN),
    .req     (req),
    .load    (state_q == IDLE),
    .advance (advance),
    .grant   (grant),
    .ptr     (unused_ptr)
  );

  // Owner mux toward the slave, READY/B routing back to the owner only.
  always_comb begin
    S_AWADDR    = sel_m1 ? M1_AWADDR  : M0_AWADDR;
    S_WDATA     = sel_m1 ? M1_WDATA   : M0_WDATA;
    S_WSTRB     = sel_m1 ? M1_WSTRB   : M0_WSTRB;
    sel_awvalid = sel_m1 ? M1_AWVALID : M0_AWVALID;
    sel_wvalid  = sel_m1 ? M1_WVALID  : M0_WVALID;
    sel_bready  = sel_m1 ? M1_BREADY  : M0_BREADY;

    S_AWVALID = in_xfer & sel_awvalid & ~aw_done_q;
    S_WVALID  = in_xfer & sel_wvalid  & ~w_done_q;
    S_BREADY  = in_xfer;

    aw_hs    = S_AWVALID & S_AWREADY;
    w_hs     = S_WVALID  & S_WREADY;
    b_hs     = in_xfer & S_BVALID & ~b_done_q;
    all_done = (aw_done_q | aw_hs) & (w_done_q | w_hs) & (b_done_q | b_hs);
    tmo_fire = (TIMEOUT_CYCLES != 0) && in_xfer && !all_done && (tmo_cnt_q == TMO_LAST);
    advance  = in_resp & bvalid_q & sel_bready;

    M0_AWREADY = in_xfer & grant[0] & ~aw_done_q & S_AWREADY;
    M0_WREADY  = in_xfer & grant[0] & ~w_done_q  & S_WREADY;
    M1_AWREADY = in_xfer & grant[1] & ~aw_done_q & S_AWREADY;
    M1_WREADY  = in_xfer & grant[1] & ~w_done_q  & S_WREADY;
    M0_BVALID  = bvalid_q & grant[0];
    M1_BVALID  = bvalid_q & grant[1];
    M0_BRESP   = M0_BVALID ? bresp_q : RESP_OKAY;
    M1_BRESP   = M1_BVALID ? bresp_q : RESP_OKAY;
  end

  // Next-state decode for the IDLE/XFER/RESP sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00)        state_d = XFER;
      XFER:    if (all_done || tmo_fire) state_d = RESP;
      RESP:    if (advance)             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // State, done flags, buffered B response and timeout counter.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        XFER: begin
          tmo_cnt_q <= tmo_cnt_q + CW'(1);
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (b_hs) begin
            b_done_q <= 1'b1;
            bresp_q  <= S_BRESP;
          end
          if (tmo_fire)              bresp_q  <= RESP_SLVERR;
          if (all_done || tmo_fire)  bvalid_q <= 1'b1;
        end
        RESP: begin
          if (advance) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            tmo_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
